axi4_slave_mem: RTL and testbench

- AXI4 slave memory responder.
- Attaches to the slave side of the team's AXI4 bus interface and services write bursts (AW/W/B) and read bursts (AR/R) against an internal word-addressed RAM.
- Serves as the reference slave/DUT for the AXI4 VIP master, monitor and scoreboard.
- Supports FIXED, INCR and WRAP bursts, narrow transfers and write strobes; no ID, lock, cache, prot or QoS signals.

---
 rtl/axi4_slave_mem.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_slave_mem
//  Purpose  : AXI4 slave memory responder. Services write bursts (AW/W/B) and
//             read bursts (AR/R) against an internal word-addressed RAM.
//             Supports FIXED/INCR/WRAP bursts, narrow transfers and write
//             strobes. No ID/lock/cache/prot/QoS.
//  Ports    : aclk, aresetn (async, active low)
//             AW: awaddr awlen awsize awburst awvalid -> awready
//             W : wdata wstrb wlast wvalid            -> wready
//             B : bresp bvalid                        <- bready
//             AR: araddr arlen arsize arburst arvalid -> arready
//             R : rdata rresp rlast rvalid            <- rready
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int         c_BYTE_LANES = DATA_WIDTH / 8;
    localparam int         c_LANE_BITS  = $clog2(c_BYTE_LANES);
    localparam int         c_IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] c_INCR       = 2'd1;
    localparam logic [1:0] c_WRAP       = 2'd2;
    localparam logic [1:0] c_OKAY       = 2'b00;
    localparam logic [1:0] c_SLVERR     = 2'b10;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    // Address of the beat following addr.
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] n, span, lower, nxt;
        n     = ADDR_WIDTH'(1) << size;
        span  = n * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        lower = addr & ~(span - ADDR_WIDTH'(1));
        nxt   = addr + n;
        case (burst)
            c_INCR:  f_next_addr = (addr & ~(n - ADDR_WIDTH'(1))) + n;
            c_WRAP:  f_next_addr = (nxt == lower + span) ? lower : nxt;
            default: f_next_addr = addr;
        endcase
    endfunction

    // Conditions that fail every beat of a burst.
    function automatic logic f_burst_err(
        input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] n_mask;
        n_mask      = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        f_burst_err = 1'b0;
        if (burst == 2'b11) f_burst_err = 1'b1;
        if (size > 3'(c_LANE_BITS)) f_burst_err = 1'b1;
        if (burst == c_WRAP) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
                f_burst_err = 1'b1;
            if ((addr & n_mask) != '0) f_burst_err = 1'b1;
        end
    endfunction

    function automatic logic f_oor(input logic [ADDR_WIDTH-1:0] addr);
        f_oor = (addr >> c_LANE_BITS) >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [c_IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
        f_idx = c_IDX_W'(addr >> c_LANE_BITS);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------ write
    logic [1:0]            r_wstate;
    logic                  r_awready, r_wready, r_bvalid;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen, r_wcnt;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst;
    logic                  r_wburst_err, r_werr;

    logic w_wbeat_err, w_wlast_bad, w_wr_en;
    assign w_wbeat_err = r_wburst_err | f_oor(r_waddr);
    assign w_wlast_bad = wlast != (r_wcnt == r_wlen);
    assign w_wr_en     = (r_wstate == c_W_DATA) && r_wready && wvalid && !w_wbeat_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate     <= c_W_IDLE;
            r_awready    <= 1'b1;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= c_OKAY;
            r_waddr      <= '0;
            r_wlen       <= '0;
            r_wcnt       <= '0;
            r_wsize      <= '0;
            r_wburst     <= '0;
            r_wburst_err <= 1'b0;
            r_werr       <= 1'b0;
        end else begin
            case (r_wstate)
                c_W_IDLE: if (awvalid && r_awready) begin
                    r_waddr      <= awaddr;
                    r_wlen       <= awlen;
                    r_wsize      <= awsize;
                    r_wburst     <= awburst;
                    r_wburst_err <= f_burst_err(awaddr, awlen, awsize, awburst);
                    r_wcnt       <= '0;
                    r_werr       <= 1'b0;
                    r_awready    <= 1'b0;
                    r_wready     <= 1'b1;
                    r_wstate     <= c_W_DATA;
                end
                c_W_DATA: if (wvalid && r_wready) begin
                    r_waddr <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                    r_wcnt  <= r_wcnt + 8'd1;
                    r_werr  <= r_werr | w_wbeat_err | w_wlast_bad;
                    // The beat count, not wlast, closes the burst.
                    if (r_wcnt == r_wlen) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= (r_werr | w_wbeat_err | w_wlast_bad) ? c_SLVERR : c_OKAY;
                        r_wstate <= c_W_RESP;
                    end
                end
                c_W_RESP: if (bready) begin
                    r_bvalid  <= 1'b0;
                    r_bresp   <= c_OKAY;
                    r_awready <= 1'b1;
                    r_wstate  <= c_W_IDLE;
                end
                default: begin
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_wstate  <= c_W_IDLE;
                end
            endcase
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < c_BYTE_LANES; i++) begin
                if (wstrb[i]) r_mem[f_idx(r_waddr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    logic [0:0]            r_rstate;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen, r_rcnt;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;
    logic                  r_rburst_err;

    logic [ADDR_WIDTH-1:0] w_rnext_addr;
    logic                  w_ar_err, w_rnext_err;
    assign w_rnext_addr = f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
    assign w_ar_err     = f_burst_err(araddr, arlen, arsize, arburst);
    assign w_rnext_err  = r_rburst_err | f_oor(w_rnext_addr);

    // rdata is captured from the RAM on the launching edge, so a write on the
    // same edge only shows up in a later beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate     <= c_R_IDLE;
            r_arready    <= 1'b1;
            r_rvalid     <= 1'b0;
            r_rlast      <= 1'b0;
            r_rresp      <= c_OKAY;
            r_rdata      <= '0;
            r_raddr      <= '0;
            r_rlen       <= '0;
            r_rcnt       <= '0;
            r_rsize      <= '0;
            r_rburst     <= '0;
            r_rburst_err <= 1'b0;
        end else begin
            case (r_rstate)
                c_R_IDLE: if (arvalid && r_arready) begin
                    r_raddr      <= araddr;
                    r_rlen       <= arlen;
                    r_rsize      <= arsize;
                    r_rburst     <= arburst;
                    r_rburst_err <= w_ar_err;
                    r_rcnt       <= '0;
                    r_arready    <= 1'b0;
                    r_rvalid     <= 1'b1;
                    r_rlast      <= (arlen == 8'd0);
                    if (w_ar_err || f_oor(araddr)) begin
                        r_rdata <= '0;
                        r_rresp <= c_SLVERR;
                    end else begin
                        r_rdata <= r_mem[f_idx(araddr)];
                        r_rresp <= c_OKAY;
                    end
                    r_rstate <= c_R_DATA;
                end
                c_R_DATA: if (rready) begin
                    if (r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_rresp   <= c_OKAY;
                        r_rdata   <= '0;
                        r_arready <= 1'b1;
                        r_rstate  <= c_R_IDLE;
                    end else begin
                        r_raddr <= w_rnext_addr;
                        r_rcnt  <= r_rcnt + 8'd1;
                        r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        if (w_rnext_err) begin
                            r_rdata <= '0;
                            r_rresp <= c_SLVERR;
                        end else begin
                            r_rdata <= r_mem[f_idx(w_rnext_addr)];
                            r_rresp <= c_OKAY;
                        end
                    end
                end
                default: begin
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                    r_rstate  <= c_R_IDLE;
                end
            endcase
        end
    end

    // Ready flops reset to 1 so the channels accept in the first cycle after
    // release; gating with aresetn keeps them low while reset is asserted.
    assign awready = r_awready & aresetn;
    assign arready = r_arready & aresetn;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_slave_mem
//  Purpose  : Self-checking bench for axi4_slave_mem (32-bit, 256 words).
//             Directed vector table, hand-written corner sequences and a
//             randomized phase checked against a byte-array memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_slave_mem;

    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int DEPTH     = 256;
    localparam int MEM_BYTES = DEPTH * 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [7:0]    awlen = '0, arlen = '0;
    logic [2:0]    awsize = '0, arsize = '0;
    logic [1:0]    awburst = '0, arburst = '0;
    logic          awvalid = 1'b0, arvalid = 1'b0, awready, arready;
    logic [DW-1:0] wdata = '0, rdata;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0, wvalid = 1'b0, wready;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready = 1'b0;
    logic          rlast, rvalid, rready = 1'b0;

    axi4_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]  mbytes [MEM_BYTES];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] rd_d [256];
    logic [1:0]  rd_r [256];
    logic        rd_l [256];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        int          wlast_beat;
        logic [1:0]  exp_resp;
        logic [3:0][31:0] d;
    } vec_t;

    function automatic vec_t mkv(bit wr, logic [31:0] a, logic [7:0] len, logic [2:0] sz,
                                 logic [1:0] bu, logic [3:0] st, int wlb, logic [1:0] er,
                                 logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3);
        vec_t v;
        v.is_wr = wr; v.addr = a; v.len = len; v.size = sz; v.burst = bu; v.strb = st;
        v.wlast_beat = wlb; v.exp_resp = er;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string what);
        n_vec++;
        n_miss++;
        $display("FAIL timeout_%s: got no handshake expected handshake", what);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    endtask

    // ---------------------------------------------------------- reference model
    function automatic longint beat_addr(longint a0, int len, int size, int burst, int i);
        longint n, span, lower;
        n = longint'(1) << size;
        case (burst)
            0: return a0;
            1: return (i == 0) ? a0 : (a0 / n) * n + longint'(i) * n;
            default: begin
                span  = n * longint'(len + 1);
                lower = (a0 / span) * span;
                return lower + ((a0 - lower) + longint'(i) * n) % span;
            end
        endcase
    endfunction

    function automatic bit burst_bad(longint a0, int len, int size, int burst);
        if (burst == 3 || size > 2) return 1'b1;
        if (burst == 2 && (!(len == 1 || len == 3 || len == 7 || len == 15) ||
                           (a0 % (longint'(1) << size)) != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit beat_bad(longint a0, int len, int size, int burst, int i);
        if (burst_bad(a0, len, size, burst)) return 1'b1;
        return (beat_addr(a0, len, size, burst, i) / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] model_word(longint a);
        longint w;
        w = a / 4;
        return {mbytes[w*4+3], mbytes[w*4+2], mbytes[w*4+1], mbytes[w*4]};
    endfunction

    function automatic void model_write(longint a0, int len, int size, int burst);
        longint w;
        for (int i = 0; i <= len; i++) begin
            if (!beat_bad(a0, len, size, burst, i)) begin
                w = beat_addr(a0, len, size, burst, i) / 4;
                for (int j = 0; j < 4; j++)
                    if (ws[i][j]) mbytes[w*4+j] = wd[i][8*j +: 8];
            end
        end
    endfunction

    // ------------------------------------------------------------ bus drivers
    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int wlast_beat, input bit gaps,
                            input int bdelay, output logic [1:0] resp);
        int t;
        logic [1:0] first;
        @(negedge aclk);
        awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready) begin @(negedge aclk); t++; if (t > 1000) timeout("aw"); end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_beat);
            t = 0;
            while (!wready) begin @(negedge aclk); t++; if (t > 1000) timeout("w"); end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (bdelay == 0) check("b_latency", 64'(bvalid), 64'd1);
        first = bresp;
        for (int k = 0; k < bdelay; k++) begin
            check("b_hold", 64'({bvalid, bresp, awready}), 64'({1'b1, first, 1'b0}));
            @(negedge aclk);
        end
        bready = 1'b1;
        t = 0;
        while (!bvalid) begin @(negedge aclk); t++; if (t > 1000) timeout("b"); end
        resp = bresp;
        @(negedge aclk);
        bready = 1'b0;
        check("aw_after_b", 64'(awready), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit rand_rdy);
        int t, beats, gaps;
        bit stalled;
        logic [35:0] prev;
        @(negedge aclk);
        araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready) begin @(negedge aclk); t++; if (t > 1000) timeout("ar"); end
        @(negedge aclk);
        arvalid = 1'b0;
        beats = 0; gaps = 0; stalled = 1'b0; prev = '0; t = 0;
        while (beats <= int'(len)) begin
            if (stalled) check("r_stable", 64'({rvalid, rdata, rresp, rlast}), 64'(prev));
            rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid) begin
                if (rready) begin
                    rd_d[beats] = rdata; rd_r[beats] = rresp; rd_l[beats] = rlast;
                    beats++; stalled = 1'b0;
                end else begin
                    stalled = 1'b1; prev = {rvalid, rdata, rresp, rlast};
                end
            end else gaps++;
            @(negedge aclk);
            t++; if (t > 2000) timeout("r");
        end
        rready = 1'b0;
        if (!rand_rdy) check("r_b2b_gaps", 64'(gaps), 64'd0);
    endtask

    task automatic check_read_model(input string tag, input logic [31:0] a, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
        for (int i = 0; i <= int'(len); i++) begin
            if (beat_bad(a, len, size, burst, i)) begin
                check($sformatf("%s_beat%0d_data", tag, i), 64'(rd_d[i]), 64'd0);
                check($sformatf("%s_beat%0d_resp", tag, i), 64'(rd_r[i]), 64'd2);
            end else begin
                check($sformatf("%s_beat%0d_data", tag, i), 64'(rd_d[i]),
                      64'(model_word(beat_addr(a, len, size, burst, i))));
                check($sformatf("%s_beat%0d_resp", tag, i), 64'(rd_r[i]), 64'd0);
            end
            check($sformatf("%s_beat%0d_last", tag, i), 64'(rd_l[i]), 64'(i == int'(len)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt [13];
        logic [1:0]  resp, eresp;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bu;
        int          wlb, r;

        // ------------------------------------------------------------- reset
        repeat (3) @(negedge aclk);
        check("reset_outputs",
              64'({awready, arready, wready, bvalid, bresp, rvalid, rresp, rlast, rdata}), 64'd0);
        aresetn = 1'b1;
        #1;
        check("ready_after_reset", 64'({awready, arready}), 64'd3);

        // ---------------------------------------------------- directed table
        vt[0]  = mkv(1, 32'h10,  0, 2, 1, 4'hF, 0, 2'b00, 32'hDEADBEEF, 0, 0, 0);
        vt[1]  = mkv(0, 32'h10,  0, 2, 1, 4'hF, 0, 2'b00, 32'hDEADBEEF, 0, 0, 0);
        vt[2]  = mkv(1, 32'h100, 3, 2, 1, 4'hF, 3, 2'b00, 32'h11, 32'h22, 32'h33, 32'h44);
        vt[3]  = mkv(0, 32'h100, 3, 2, 1, 4'hF, 3, 2'b00, 32'h11, 32'h22, 32'h33, 32'h44);
        vt[4]  = mkv(1, 32'h200, 3, 2, 1, 4'hF, 3, 2'b00, 32'h0, 32'h1, 32'h2, 32'h3);
        vt[5]  = mkv(0, 32'h208, 3, 2, 2, 4'hF, 3, 2'b00, 32'h2, 32'h3, 32'h0, 32'h1);
        vt[6]  = mkv(1, 32'h300, 0, 2, 1, 4'hF, 0, 2'b00, 32'hFFFFFFFF, 0, 0, 0);
        vt[7]  = mkv(1, 32'h301, 0, 0, 1, 4'h2, 0, 2'b00, 32'h0000AB00, 0, 0, 0);
        vt[8]  = mkv(0, 32'h300, 0, 2, 1, 4'hF, 0, 2'b00, 32'hFFFFABFF, 0, 0, 0);
        vt[9]  = mkv(0, DEPTH*4, 0, 2, 1, 4'hF, 0, 2'b10, 32'h0, 0, 0, 0);
        vt[10] = mkv(1, 32'h300, 0, 2, 3, 4'hF, 0, 2'b10, 32'h12345678, 0, 0, 0);
        vt[11] = mkv(0, 32'h300, 0, 2, 1, 4'hF, 0, 2'b00, 32'hFFFFABFF, 0, 0, 0);
        vt[12] = mkv(1, 32'h180, 3, 2, 1, 4'hF, 1, 2'b10, 32'h1, 32'h2, 32'h3, 32'h4);

        for (int k = 0; k < 13; k++) begin
            if (vt[k].is_wr) begin
                for (int i = 0; i < 4; i++) begin wd[i] = vt[k].d[i]; ws[i] = vt[k].strb; end
                do_write(vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].wlast_beat,
                         1'b0, 0, resp);
                check($sformatf("vec%0d_bresp", k), 64'(resp), 64'(vt[k].exp_resp));
                model_write(vt[k].addr, vt[k].len, vt[k].size, vt[k].burst);
            end else begin
                do_read(vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, 1'b0);
                for (int i = 0; i <= int'(vt[k].len); i++) begin
                    check($sformatf("vec%0d_beat%0d_data", k, i), 64'(rd_d[i]), 64'(vt[k].d[i]));
                    check($sformatf("vec%0d_beat%0d_resp", k, i), 64'(rd_r[i]), 64'(vt[k].exp_resp));
                    check($sformatf("vec%0d_beat%0d_last", k, i), 64'(rd_l[i]),
                          64'(i == int'(vt[k].len)));
                end
            end
        end

        // ------------------------------------------- fill RAM with known data
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(32'h0, 8'd255, 3'd2, 2'd1, 255, 1'b0, 0, resp);
        check("init_bresp", 64'(resp), 64'd0);
        model_write(0, 255, 2, 1);

        // ----------------------------------------- B backpressure (5 cycles)
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(32'h40, 8'd0, 3'd2, 2'd1, 0, 1'b0, 5, resp);
        check("bp_bresp", 64'(resp), 64'd0);
        model_write(32'h40, 0, 2, 1);

        // ------------------------------------------------- randomized phase
        for (int it = 0; it < 60; it++) begin
            r  = $urandom_range(0, 9);
            bu = (r < 2) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (bu == 2'd2) begin
                r   = $urandom_range(0, 4);
                len = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : (r == 3) ? 8'd15 : 8'd2;
            end else len = 8'($urandom_range(0, 7));
            a = 32'($urandom_range(0, MEM_BYTES + 63));
            if (bu == 2'd2 && $urandom_range(0, 5) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                wlb   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : int'(len);
                eresp = (wlb != int'(len)) ? 2'b10 : 2'b00;
                for (int i = 0; i <= int'(len); i++)
                    if (beat_bad(a, len, sz, bu, i)) eresp = 2'b10;
                do_write(a, len, sz, bu, wlb, 1'b1, $urandom_range(0, 2), resp);
                check($sformatf("rnd%0d_bresp", it), 64'(resp), 64'(eresp));
                model_write(a, len, sz, bu);
            end else begin
                do_read(a, len, sz, bu, 1'b1);
                check_read_model($sformatf("rnd%0d", it), a, len, sz, bu);
            end
        end

        // ------------------------------------------------ reset mid-read
        @(negedge aclk);
        araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        begin
            int t;
            t = 0;
            while (!arready) begin @(negedge aclk); t++; if (t > 1000) timeout("ar_rst"); end
        end
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(negedge aclk);
        rready = 1'b0;
        check("rst_pre_rvalid", 64'(rvalid), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({rvalid, rlast, arready, awready, bvalid}), 64'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("rst_release_ready", 64'({awready, arready}), 64'd3);
        do_read(32'h20, 8'd3, 3'd2, 2'd1, 1'b0);
        check_read_model("post_rst", 32'h20, 8'd3, 3'd2, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
